// File: rtl/fa_pkg.sv
// Shared definitions for the feeder, engine and writeback serializer.
package fa_pkg;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 30;
    localparam int unsigned MAX_LANES = 64;

    typedef enum logic {
        FETCH_IDLE,
        FETCH_BUSY
    } fetch_state_e;

    // Extract lane idx from a packed lane vector (lane 0 in the low bits).
    function automatic logic [DW-1:0] lane_slice(input logic [MAX_LANES*DW-1:0] vec,
                                                 input int unsigned idx);
        return vec[idx*DW +: DW];
    endfunction

endpackage

// File: rtl/burst_bank.sv
// One BURST_LEN x DW lane register file with clear, indexed write, full flag and length.
module burst_bank #(
    parameter int unsigned BURST_LEN = 16,
    parameter int unsigned DW        = fa_pkg::DW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    we,
    input  logic [7:0]              idx,
    input  logic [DW-1:0]           wdata,
    input  logic                    fill_done,
    input  logic [7:0]              fill_len,
    input  logic                    consume,
    output logic [BURST_LEN*DW-1:0] data,
    output logic                    full,
    output logic [7:0]              len
);

    logic [BURST_LEN*DW-1:0] data_q;
    logic                    full_q;
    logic [7:0]              len_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            full_q <= 1'b0;
            len_q  <= 8'd0;
        end else begin
            // Clearing on accept keeps lanes >= len at zero for the MAC array.
            if (clr) begin
                data_q <= '0;
            end else if (we) begin
                for (int i = 0; i < int'(BURST_LEN); i++) begin
                    if (idx == 8'(i)) data_q[i*DW +: DW] <= wdata;
                end
            end
            if (fill_done) begin
                full_q <= 1'b1;
                len_q  <= fill_len;
            end else if (consume) begin
                full_q <= 1'b0;
            end
        end
    end

    assign data = data_q;
    assign full = full_q;
    assign len  = len_q;

endmodule

// File: rtl/burst_deser.sv
// DMA burst fetch + deserializer feeding the engine; BURST_DESER_PINGPONG_EN selects two banks.
module burst_deser #(
    parameter int unsigned BURST_LEN = 16,
    parameter int unsigned DW        = fa_pkg::DW,
    parameter int unsigned AW        = fa_pkg::AW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [AW-1:0]           req_addr,
    input  logic [7:0]              req_len,
    output logic                    dma_reads_en,
    output logic [AW-1:0]           dma_addr,
    input  logic [DW-1:0]           dma_ob_data,
    input  logic                    dma_ob_we,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BURST_LEN*DW-1:0] out_data,
    output logic [7:0]              out_len,
    output logic                    err_overrun
);
    import fa_pkg::*;

`ifdef BURST_DESER_PINGPONG_EN
    localparam int unsigned NUM_BANKS = 2;
`else
    localparam int unsigned NUM_BANKS = 1;
`endif
    // XOR mask for bank pointers: pointers stay at 0 with a single bank.
    localparam logic PING_PONG = 1'(NUM_BANKS - 1);

    fetch_state_e state;
    logic [7:0]   len_q, cnt_q, req_len_c;
    logic         wr_bank, rd_bank, wr_full;
    logic         accept, word_we, last_word, consume;

    logic                    bank_full [NUM_BANKS];
    logic [7:0]              bank_len  [NUM_BANKS];
    logic [BURST_LEN*DW-1:0] bank_data [NUM_BANKS];

    assign req_len_c = (req_len == 8'd0 || req_len > 8'(BURST_LEN)) ? 8'(BURST_LEN) : req_len;

    always_comb begin
        wr_full   = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_len   = 8'd0;
        for (int b = 0; b < int'(NUM_BANKS); b++) begin
            if (wr_bank == 1'(b)) wr_full = bank_full[b];
            if (rd_bank == 1'(b)) begin
                out_valid = bank_full[b];
                out_data  = bank_data[b];
                out_len   = bank_len[b];
            end
        end
    end

    assign req_ready = (state == FETCH_IDLE) && !wr_full;
    assign accept    = req_valid && req_ready;
    assign word_we   = (state == FETCH_BUSY) && dma_ob_we;
    assign last_word = word_we && (cnt_q == len_q - 8'd1);
    assign consume   = out_valid && out_ready;

    for (genvar b = 0; b < int'(NUM_BANKS); b++) begin : g_bank
        burst_bank #(
            .BURST_LEN(BURST_LEN),
            .DW       (DW)
        ) u_bank (
            .clk      (clk),
            .rst      (rst),
            .clr      (accept && (wr_bank == 1'(b))),
            .we       (word_we && (wr_bank == 1'(b))),
            .idx      (cnt_q),
            .wdata    (dma_ob_data),
            .fill_done(last_word && (wr_bank == 1'(b))),
            .fill_len (len_q),
            .consume  (consume && (rd_bank == 1'(b))),
            .data     (bank_data[b]),
            .full     (bank_full[b]),
            .len      (bank_len[b])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= FETCH_IDLE;
            len_q        <= 8'd0;
            cnt_q        <= 8'd0;
            wr_bank      <= 1'b0;
            rd_bank      <= 1'b0;
            dma_reads_en <= 1'b0;
            dma_addr     <= '0;
            err_overrun  <= 1'b0;
        end else begin
            if (consume) rd_bank <= rd_bank ^ PING_PONG;
            case (state)
                FETCH_IDLE: begin
                    if (dma_ob_we) err_overrun <= 1'b1;
                    if (accept) begin
                        state        <= FETCH_BUSY;
                        len_q        <= req_len_c;
                        cnt_q        <= 8'd0;
                        dma_reads_en <= 1'b1;
                        dma_addr     <= req_addr;
                    end
                end
                FETCH_BUSY: begin
                    if (dma_ob_we) begin
                        cnt_q <= last_word ? 8'd0 : cnt_q + 8'd1;
                        if (last_word) begin
                            dma_reads_en <= 1'b0;
                            wr_bank      <= wr_bank ^ PING_PONG;
                            state        <= FETCH_IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_burst_deser.sv
// Self-checking bench for burst_deser: table of bursts, hand sequences and random traffic.
module tb_burst_deser;
    import fa_pkg::*;

    localparam int unsigned BL = 16;
    localparam int unsigned W  = BL * 16;
`ifdef BURST_DESER_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready;
    logic [29:0]   req_addr;
    logic [7:0]    req_len;
    logic          dma_reads_en;
    logic [29:0]   dma_addr;
    logic [15:0]   dma_ob_data;
    logic          dma_ob_we;
    logic          out_valid, out_ready;
    logic [W-1:0]  out_data;
    logic [7:0]    out_len;
    logic          err_overrun;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_q[$];
    logic [7:0]   exp_len_q[$];

    burst_deser #(.BURST_LEN(BL)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .dma_reads_en(dma_reads_en),
        .dma_addr    (dma_addr),
        .dma_ob_data (dma_ob_data),
        .dma_ob_we   (dma_ob_we),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_len     (out_len),
        .err_overrun (err_overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    function automatic int clamp_len(input logic [7:0] len);
        return (len == 8'd0 || int'(len) > int'(BL)) ? int'(BL) : int'(len);
    endfunction

    task automatic run_burst(input logic [29:0] addr, input logic [7:0] len, input int gap,
                             input logic [15:0] base);
        int n;
        int clen;
        logic [W-1:0] vec;
        clen = clamp_len(len);
        req_valid = 1'b1;
        req_addr  = addr;
        req_len   = len;
        n = 0;
        while (!req_ready && n < 200) begin
            tick();
            n++;
        end
        check("req_ready_wait", W'(req_ready), W'(1));
        tick();
        req_valid = 1'b0;
        check("rd_en_start", W'(dma_reads_en), W'(1));
        check("dma_addr", W'(dma_addr), W'(addr));
        check("ready_busy", W'(req_ready), W'(0));
        vec = '0;
        for (int i = 0; i < clen; i++) begin
            for (int g = 0; g < gap; g++) tick();
            dma_ob_we   = 1'b1;
            dma_ob_data = base + 16'(i);
            vec[i*16 +: 16] = base + 16'(i);
            tick();
            dma_ob_we = 1'b0;
            if (i < clen - 1) check("rd_en_mid", W'(dma_reads_en), W'(1));
        end
        check("rd_en_end", W'(dma_reads_en), W'(0));
        check("valid_after_last", W'(out_valid), W'(1));
        exp_q.push_back(vec);
        exp_len_q.push_back(8'(clen));
    endtask

    task automatic consume();
        check("cons_valid", W'(out_valid), W'(1));
        check("cons_data", out_data, exp_q[0]);
        check("cons_len", W'(out_len), W'(exp_len_q[0]));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        void'(exp_q.pop_front());
        void'(exp_len_q.pop_front());
    endtask

    typedef struct {
        logic [29:0] addr;
        logic [7:0]  len;
        int          gap;
        logic [15:0] base;
        logic [7:0]  exp_len;
    } vec_t;

    vec_t tbl[6];
    logic [MAX_LANES*16-1:0] wide;

    initial begin
        tbl[0] = '{30'h100, 8'd16, 0, 16'h3C00, 8'd16};
        tbl[1] = '{30'h200, 8'd3,  2, 16'hA000, 8'd3};
        tbl[2] = '{30'h300, 8'd0,  0, 16'h1000, 8'd16};
        tbl[3] = '{30'h400, 8'd20, 1, 16'h2000, 8'd16};
        tbl[4] = '{30'h500, 8'd1,  0, 16'hBEEF, 8'd1};
        tbl[5] = '{30'h600, 8'd15, 0, 16'h5000, 8'd15};

        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0;
        dma_ob_data = '0; dma_ob_we = 1'b0; out_ready = 1'b0;
        tick(); tick();
        check("rst_rd_en", W'(dma_reads_en), W'(0));
        check("rst_addr", W'(dma_addr), W'(0));
        check("rst_valid", W'(out_valid), W'(0));
        check("rst_data", out_data, W'(0));
        check("rst_len", W'(out_len), W'(0));
        check("rst_err", W'(err_overrun), W'(0));
        rst = 1'b0;
        tick();
        check("idle_ready", W'(req_ready), W'(1));

        for (int k = 0; k < 6; k++) begin
            run_burst(tbl[k].addr, tbl[k].len, tbl[k].gap, tbl[k].base);
            check("tbl_len", W'(out_len), W'(tbl[k].exp_len));
            wide = '0;
            wide[W-1:0] = out_data;
            check("tbl_lane_last", W'(lane_slice(wide, int'(tbl[k].exp_len) - 1)),
                  W'(tbl[k].base + 16'(tbl[k].exp_len) - 16'd1));
            check("tbl_lane_after", W'(lane_slice(wide, int'(tbl[k].exp_len))), W'(0));
            consume();
        end

`ifdef BURST_DESER_PINGPONG_EN
        run_burst(30'h1000, 8'd16, 0, 16'h1100);
        run_burst(30'h2000, 8'd16, 0, 16'h2200);
        req_valid = 1'b1; req_addr = 30'h3000; req_len = 8'd16;
        tick();
        check("pp_third_stall", W'(req_ready), W'(0));
        check("pp_no_read", W'(dma_reads_en), W'(0));
        req_valid = 1'b0;
        consume();
        check("pp_bank1_data", out_data, exp_q[0]);
        check("pp_ready_rise", W'(req_ready), W'(1));
        consume();
`else
        run_burst(30'h1000, 8'd16, 0, 16'h1100);
        req_valid = 1'b1; req_addr = 30'h2000; req_len = 8'd4;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("sb_stall", W'(req_ready), W'(0));
            check("sb_no_read", W'(dma_reads_en), W'(0));
        end
        consume();
        check("sb_ready_rise", W'(req_ready), W'(1));
        run_burst(30'h2000, 8'd4, 0, 16'h2200);
        consume();
`endif

        // Overrun: stray DMA word while idle with a held vector.
        run_burst(30'h700, 8'd5, 0, 16'h7000);
        dma_ob_we = 1'b1; dma_ob_data = 16'hDEAD;
        tick();
        dma_ob_we = 1'b0;
        check("ovr_err", W'(err_overrun), W'(1));
        check("ovr_valid", W'(out_valid), W'(1));
        check("ovr_data", out_data, exp_q[0]);
        consume();
        tick();
        check("ovr_sticky", W'(err_overrun), W'(1));

        // Reset after 5 of 16 words.
        req_valid = 1'b1; req_addr = 30'h800; req_len = 8'd16;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            dma_ob_we = 1'b1; dma_ob_data = 16'h8000 + 16'(i);
            tick();
        end
        dma_ob_we = 1'b0;
        rst = 1'b1;
        tick();
        check("mid_rd_en", W'(dma_reads_en), W'(0));
        check("mid_addr", W'(dma_addr), W'(0));
        check("mid_valid", W'(out_valid), W'(0));
        check("mid_data", out_data, W'(0));
        check("mid_err", W'(err_overrun), W'(0));
        rst = 1'b0;
        dma_ob_we = 1'b1; dma_ob_data = 16'h8005;
        tick();
        dma_ob_we = 1'b0;
        check("late_err", W'(err_overrun), W'(1));
        check("late_valid", W'(out_valid), W'(0));
        run_burst(30'h900, 8'd16, 0, 16'h9000);
        consume();

        // Random traffic against the queue model.
        for (int it = 0; it < 40; it++) begin
            check("rnd_valid", W'(out_valid), W'(exp_q.size() > 0));
            check("rnd_ready", W'(req_ready), W'(exp_q.size() < NB));
            if (exp_q.size() > 0 && ($urandom_range(0, 2) == 0 || exp_q.size() >= NB)) begin
                consume();
            end else if (exp_q.size() < NB) begin
                run_burst(30'($urandom), 8'($urandom_range(0, 20)), int'($urandom_range(0, 2)),
                          16'($urandom));
            end
        end
        while (exp_q.size() > 0) consume();
        check("final_valid", W'(out_valid), W'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
